adc_avg_sequencer: RTL and testbench
====================================

// Module: adc_avg_sequencer
// PURPOSE
//  Upstream front-end for the 8-bit ALU/SPI CPU core. It converts the core's NXT measurement request into ADC
//  conversion cycles and averages 2^AVG_LOG2 samples. It then presents the 10-bit result on ADC_PI and raises
//  APP_DONE, which the core polls. It sits between the off-core SAR ADC and the core's ADC_PI/APP_DONE pads.
// PARAMETERS
//  DATA_WIDTH   10   ADC sample / result width
//  AVG_LOG2     2    log2 of samples averaged per measurement (0 = single sample)
//  SETTLE_CYC   8    CLK cycles waited before every SOC (analog settling)
//  TIMEOUT_CYC  255  max CLK cycles in WAIT_EOC before error
// PORTS
//  CLK       in   1           system clock; single clock domain
//  RST       in   1           synchronous, active-high reset
//  NXT       in   2           command from core: 2'b01 start, 2'b10 abort, others no-op
//  ADC_DATA  in   DATA_WIDTH  ADC conversion result, valid only when ADC_EOC=1
//  ADC_EOC   in   1           1-cycle end-of-conversion strobe from ADC
//  ADC_SOC   out  1           1-cycle start-of-conversion pulse to ADC
//  ADC_PI    out  DATA_WIDTH  averaged result to core, held stable until next DONE
//  APP_DONE  out  1           measurement complete, level; high in DONE until next start or abort
//  BUSY      out  1           high in any state except IDLE and DONE
//  ERR       out  1           sticky EOC-timeout flag, cleared on next accepted start
// BEHAVIOUR
//  - Reset: CLK edge with RST=1 forces all outputs to 0, state to IDLE, acc/counters/nxt_q to 0; RST wins over all inputs.
//  - NXT is registered into nxt_q each cycle.
//  - start_ev = (NXT==2'b01) && (nxt_q!=2'b01); a held level is one start.
//  - abort_ev = (NXT==2'b10).
//  - FSM states: IDLE, SETTLE, SOC, WAIT_EOC, ACC, DONE.
//  - IDLE/DONE --start_ev--> SETTLE:
//    - clear acc, sample count and ERR
//    - drop APP_DONE in the same edge
//    - ADC_PI keeps its old value
//  - SETTLE: count SETTLE_CYC cycles, then go to SOC. With SETTLE_CYC=0, SETTLE lasts exactly 1 cycle.
//  - SOC: ADC_SOC=1 for exactly this one cycle, then go to WAIT_EOC with the timeout counter cleared.
//  - WAIT_EOC: on ADC_EOC=1, capture ADC_DATA and go to ACC.
//  - WAIT_EOC timeout: if the counter reaches TIMEOUT_CYC with no EOC:
//    - set ERR=1, ADC_PI=0, go to DONE
//    - if EOC arrives in the same cycle as the timeout, EOC wins
//  - ACC: acc += sample; acc is DATA_WIDTH+AVG_LOG2 bits and cannot overflow.
//  - ACC when sample count = 2^AVG_LOG2-1:
//    - go to DONE
//    - ADC_PI <= acc_next[DATA_WIDTH+AVG_LOG2-1:AVG_LOG2] (truncating divide)
//  - ACC otherwise: increment the count and go to SETTLE.
//  - DONE: APP_DONE=1, BUSY=0. Stay until start_ev or abort_ev.
//  - Abort has priority over start and over every FSM transition. It applies in any state:
//    - go to IDLE next edge
//    - APP_DONE=0, ADC_SOC=0, ERR unchanged, ADC_PI unchanged
//  - start_ev while BUSY: ignored, no restart.
//  - ADC_EOC outside WAIT_EOC: ignored, no accumulation, no error.
//  - Latency with AVG_LOG2=0, SETTLE_CYC=S and EOC E cycles after SOC: APP_DONE rises S+E+3 cycles after start_ev is sampled.
// STRUCTURE
//  - Shared define include DEFINE_ADC_SEQ.v holds state encodings, NXT command codes (NXT_START=2'b01, NXT_ABORT=2'b10), and default widths.
//  - One sub-module, adc_seq_acc:
//    - holds the accumulator, sample counter and truncating divide
//    - ports: CLK, RST, clr, add_en, din -> last, result
//  - FSM, settle/timeout counter and output registers stay in the top module. All outputs are registered.
// TESTING
//  1. AVG_LOG2=2, ADC model returns 100,101,102,103 with EOC 5 cycles after SOC, NXT=01 -> four SOC pulses; ADC_PI=101 (406>>2), APP_DONE=1, ERR=0.
//  2. ADC model never asserts EOC, TIMEOUT_CYC=255 -> ERR=1 and APP_DONE=1 exactly 256 cycles after SOC; ADC_PI=0; next NXT=01 clears ERR.
//  3. NXT=10 during second WAIT_EOC -> IDLE next edge; late EOC ignored; ADC_PI keeps prior result; APP_DONE=0; no further SOC.
//  4. NXT held at 01 for 50 cycles after DONE -> no second measurement; 00->01 toggle starts one new measurement.
//  5. RST=1 mid-ACC -> next edge: all outputs 0, IDLE; stray EOC after reset produces no accumulation.
//  6. Samples all 1023, AVG_LOG2=2 -> ADC_PI=1023 with no wrap; EOC coincident with timeout cycle -> accepted, ERR=0.

Source files
------------

// File: rtl/adc_avg_sequencer_pkg.sv
// Shared types and constants for the ADC averaging sequencer.
package adc_avg_sequencer_pkg;

  // Sequencer FSM states; StIdle must stay at zero so reset lands there.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSettle  = 3'd1,
    StSoc     = 3'd2,
    StWaitEoc = 3'd3,
    StAcc     = 3'd4,
    StDone    = 3'd5
  } seq_state_e;

  // Command codes presented by the core on NXT.
  localparam logic [1:0] NXT_START = 2'b01;
  localparam logic [1:0] NXT_ABORT = 2'b10;

  // Default geometry.
  localparam int unsigned DefDataWidth  = 10;
  localparam int unsigned DefAvgLog2    = 2;
  localparam int unsigned DefSettleCyc  = 8;
  localparam int unsigned DefTimeoutCyc = 255;

  // Width of the shared settle/timeout counter: must hold the larger terminal value.
  function automatic int unsigned cnt_width(input int unsigned settle_cyc,
                                            input int unsigned timeout_cyc);
    int unsigned max_val;
    max_val = (settle_cyc > timeout_cyc) ? settle_cyc : timeout_cyc;
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_seq_acc.sv
// Sample accumulator for the ADC sequencer: running sum, sample counter and the
// truncating divide by 2^AVG_LOG2 applied to the sum including the current sample.
module adc_seq_acc #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  add_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] result
);

  // Sum of 2^AVG_LOG2 full-scale samples always fits, so no overflow handling.
  localparam int unsigned AccW = DATA_WIDTH + AVG_LOG2;
  localparam int unsigned CntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((1 << AVG_LOG2) - 1);

  logic [AccW-1:0] acc_q, acc_d, acc_sum;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign acc_sum = acc_q + AccW'(din);
  assign last    = (cnt_q == LastCnt);
  assign result  = acc_sum[AccW-1:AVG_LOG2];

  // Next-state for the running sum and the sample index.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_en) begin
      acc_d = acc_sum;
      if (!last) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Accumulator and counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_avg_sequencer.sv
// ADC averaging sequencer: turns a start command into 2^AVG_LOG2 settle/SOC/EOC
// conversion rounds, averages the samples and reports the result with APP_DONE.
module adc_avg_sequencer
  import adc_avg_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned AVG_LOG2    = DefAvgLog2,
  parameter int unsigned SETTLE_CYC  = DefSettleCyc,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc  // must be >= 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            NXT,
  input  logic [DATA_WIDTH-1:0] ADC_DATA,
  input  logic                  ADC_EOC,
  output logic                  ADC_SOC,
  output logic [DATA_WIDTH-1:0] ADC_PI,
  output logic                  APP_DONE,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int unsigned CntW = cnt_width(SETTLE_CYC, TIMEOUT_CYC);
  // Settle exits when the counter (cleared on entry) equals SETTLE_CYC, so the
  // state spans SETTLE_CYC counted cycles plus one; SETTLE_CYC=0 gives one cycle.
  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYC);
  // Timeout fires on the cycle the counter would reach TIMEOUT_CYC.
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);

  seq_state_e            state_q, state_d;
  logic [1:0]            nxt_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sample_q;

  logic                  soc_q, soc_d;
  logic [DATA_WIDTH-1:0] pi_q, pi_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  start_ev, abort_ev, idle_or_done;
  logic                  start_go, eoc_go, timeout_go, finish_go, acc_add;
  logic                  acc_last;
  logic [DATA_WIDTH-1:0] acc_result;

  assign start_ev     = (NXT == NXT_START) && (nxt_q != NXT_START);
  assign abort_ev     = (NXT == NXT_ABORT);
  assign idle_or_done = (state_q == StIdle) || (state_q == StDone);

  // Qualified events; abort masks every one of them.
  assign start_go   = !abort_ev && start_ev && idle_or_done;
  assign eoc_go     = !abort_ev && (state_q == StWaitEoc) && ADC_EOC;
  assign timeout_go = !abort_ev && (state_q == StWaitEoc) && !ADC_EOC &&
                      (cnt_q == TimeoutLast);
  assign finish_go  = !abort_ev && (state_q == StAcc) && acc_last;
  assign acc_add    = !abort_ev && (state_q == StAcc);

  adc_seq_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .AVG_LOG2   (AVG_LOG2)
  ) u_acc (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (start_go),
    .add_en (acc_add),
    .din    (sample_q),
    .last   (acc_last),
    .result (acc_result)
  );

  // State, command history and settle/timeout counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      nxt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      nxt_q   <= NXT;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort_ev) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_ev) begin
            state_d = StSettle;
            cnt_d   = '0;
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            state_d = StSoc;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StSoc: begin
          state_d = StWaitEoc;
          cnt_d   = '0;
        end
        StWaitEoc: begin
          // EOC wins over a coincident timeout.
          if (ADC_EOC) begin
            state_d = StAcc;
          end else if (cnt_q == TimeoutLast) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StAcc: begin
          if (acc_last) begin
            state_d = StDone;
          end else begin
            state_d = StSettle;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output next-values, derived from the upcoming state so outputs stay registered.
  always_comb begin
    soc_d  = (state_d == StSoc);
    done_d = (state_d == StDone);
    busy_d = !((state_d == StIdle) || (state_d == StDone));
    err_d  = err_q;
    pi_d   = pi_q;
    if (start_go) begin
      err_d = 1'b0;
    end
    if (timeout_go) begin
      err_d = 1'b1;
      pi_d  = '0;
    end
    if (finish_go) begin
      pi_d = acc_result;
    end
  end

  // Output registers and the captured ADC sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      soc_q    <= 1'b0;
      pi_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      sample_q <= '0;
    end else begin
      soc_q  <= soc_d;
      pi_q   <= pi_d;
      done_q <= done_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      if (eoc_go) begin
        sample_q <= ADC_DATA;
      end
    end
  end

  assign ADC_SOC  = soc_q;
  assign ADC_PI   = pi_q;
  assign APP_DONE = done_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_adc_avg_sequencer.sv
// Directed bench for adc_avg_sequencer with a behavioural SAR ADC model.
module tb_adc_avg_sequencer;

  logic       CLK;
  logic       RST;
  logic [1:0] NXT;
  logic [9:0] ADC_DATA;
  logic       ADC_EOC;
  logic       ADC_SOC;
  logic [9:0] ADC_PI;
  logic       APP_DONE;
  logic       BUSY;
  logic       ERR;

  adc_avg_sequencer #(
    .DATA_WIDTH  (10),
    .AVG_LOG2    (2),
    .SETTLE_CYC  (8),
    .TIMEOUT_CYC (255)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .NXT      (NXT),
    .ADC_DATA (ADC_DATA),
    .ADC_EOC  (ADC_EOC),
    .ADC_SOC  (ADC_SOC),
    .ADC_PI   (ADC_PI),
    .APP_DONE (APP_DONE),
    .BUSY     (BUSY),
    .ERR      (ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ADC model controls (written by the main sequence only).
  logic [3:0][9:0] cur_smp    = '0;
  int unsigned     eoc_dly    = 0;   // 0 = never answer
  int              soc_base   = 0;
  logic            stray_tog  = 1'b0;
  // ADC model state (written by the model only).
  int              soc_cnt    = 0;
  int unsigned     cd         = 0;
  logic [1:0]      idx        = '0;
  logic            stray_seen = 1'b0;

  // ADC model: EOC asserted eoc_dly cycles after the cycle SOC is seen.
  initial begin
    ADC_EOC  = 1'b0;
    ADC_DATA = '0;
    forever begin
      @(negedge CLK);
      ADC_EOC = 1'b0;
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          ADC_EOC  = 1'b1;
          ADC_DATA = cur_smp[idx];
        end
      end
      if (ADC_SOC) begin
        soc_cnt = soc_cnt + 1;
        idx     = 2'(soc_cnt - soc_base - 1);
        if (eoc_dly != 0) cd = eoc_dly;
      end
      if (stray_tog != stray_seen) begin
        stray_seen = stray_tog;
        ADC_EOC    = 1'b1;
        ADC_DATA   = 10'h3FF;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One measurement: start edge, optional mid-run start pulse, wait for APP_DONE.
  task automatic run_meas(input logic [3:0][9:0] smp, input int unsigned dly,
                          input logic [1:0] hold, input int inject_at,
                          output int lat, output int socs,
                          output logic busy0, output logic err0, output logic done0);
    int cyc;
    cur_smp  = smp;
    eoc_dly  = dly;
    soc_base = soc_cnt;
    NXT      = 2'b01;
    step();
    busy0 = BUSY;
    err0  = ERR;
    done0 = APP_DONE;
    NXT   = hold;
    cyc   = 0;
    while (!APP_DONE && cyc < 3000) begin
      if (cyc == inject_at) NXT = 2'b01;
      if (cyc == inject_at + 1) NXT = hold;
      step();
      cyc++;
    end
    NXT  = hold;
    lat  = cyc;
    socs = soc_cnt - soc_base;
  endtask

  typedef struct {
    logic [3:0][9:0] smp;
    int unsigned     dly;
    int              exp_pi;
    int              exp_err;
    int              exp_lat;
    int              exp_soc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   lat, socs, base, cyc;
    logic b0, e0, d0;

    // Latency per sample = (SETTLE+1) + SOC + E + ACC = 11 + E; four samples.
    vecs[0] = '{smp: {10'd103, 10'd102, 10'd101, 10'd100}, dly: 5,
                exp_pi: 101, exp_err: 0, exp_lat: 64, exp_soc: 4};
    vecs[1] = '{smp: {10'd1023, 10'd1023, 10'd1023, 10'd1023}, dly: 3,
                exp_pi: 1023, exp_err: 0, exp_lat: 56, exp_soc: 4};
    vecs[2] = '{smp: {10'd3, 10'd0, 10'd0, 10'd0}, dly: 1,
                exp_pi: 0, exp_err: 0, exp_lat: 48, exp_soc: 4};
    // EOC lands on the timeout cycle every round: accepted, no error.
    vecs[3] = '{smp: {10'd10, 10'd9, 10'd8, 10'd7}, dly: 255,
                exp_pi: 8, exp_err: 0, exp_lat: 1064, exp_soc: 4};
    vecs[4] = '{smp: {10'd1, 10'd1023, 10'd0, 10'd512}, dly: 2,
                exp_pi: 384, exp_err: 0, exp_lat: 52, exp_soc: 4};
    // No EOC: SOC at edge 9, DONE 256 cycles later.
    vecs[5] = '{smp: {10'd5, 10'd5, 10'd5, 10'd5}, dly: 0,
                exp_pi: 0, exp_err: 1, exp_lat: 265, exp_soc: 1};

    RST = 1'b1;
    NXT = 2'b00;
    repeat (3) step();
    chk("rst_soc", int'(ADC_SOC), 0);
    chk("rst_pi", int'(ADC_PI), 0);
    chk("rst_done", int'(APP_DONE), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_err", int'(ERR), 0);
    RST = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      run_meas(vecs[i].smp, vecs[i].dly, 2'b00, -1, lat, socs, b0, e0, d0);
      chk($sformatf("v%0d_busy_start", i), int'(b0), 1);
      chk($sformatf("v%0d_done_start", i), int'(d0), 0);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_pi", i), int'(ADC_PI), vecs[i].exp_pi);
      chk($sformatf("v%0d_err", i), int'(ERR), vecs[i].exp_err);
      chk($sformatf("v%0d_done", i), int'(APP_DONE), 1);
      chk($sformatf("v%0d_busy_end", i), int'(BUSY), 0);
      chk($sformatf("v%0d_socs", i), socs, vecs[i].exp_soc);
      step();
    end

    // Abort from DONE after a timeout keeps ERR and ADC_PI.
    NXT = 2'b10;
    step();
    NXT = 2'b00;
    chk("abort_done_done", int'(APP_DONE), 0);
    chk("abort_done_err", int'(ERR), 1);
    chk("abort_done_busy", int'(BUSY), 0);
    step();

    // Next start clears ERR on its own edge.
    run_meas({10'd103, 10'd102, 10'd101, 10'd100}, 5, 2'b00, -1, lat, socs, b0, e0, d0);
    chk("errclr_err0", int'(e0), 0);
    chk("errclr_pi", int'(ADC_PI), 101);
    chk("errclr_err", int'(ERR), 0);

    // Held start level: one measurement only.
    run_meas({10'd4, 10'd4, 10'd4, 10'd4}, 2, 2'b01, -1, lat, socs, b0, e0, d0);
    chk("hold_lat", lat, 52);
    chk("hold_pi", int'(ADC_PI), 4);
    base = soc_cnt;
    repeat (50) step();
    chk("hold_socs", soc_cnt - base, 0);
    chk("hold_done", int'(APP_DONE), 1);
    chk("hold_busy", int'(BUSY), 0);
    NXT = 2'b00;
    step();
    run_meas({10'd24, 10'd20, 10'd20, 10'd20}, 1, 2'b00, -1, lat, socs, b0, e0, d0);
    chk("retoggle_lat", lat, 48);
    chk("retoggle_pi", int'(ADC_PI), 21);
    chk("retoggle_socs", socs, 4);

    // Start pulse while busy is ignored: latency unchanged.
    run_meas({10'd43, 10'd42, 10'd41, 10'd40}, 3, 2'b00, 20, lat, socs, b0, e0, d0);
    chk("busy_start_lat", lat, 56);
    chk("busy_start_pi", int'(ADC_PI), 41);
    chk("busy_start_socs", socs, 4);
    step();

    // Abort during the second WAIT_EOC; the late EOC must be ignored.
    cur_smp  = {10'd200, 10'd200, 10'd200, 10'd200};
    eoc_dly  = 6;
    soc_base = soc_cnt;
    NXT      = 2'b01;
    step();
    NXT = 2'b00;
    cyc = 0;
    while (soc_cnt - soc_base < 2 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("abort_reach_soc2", soc_cnt - soc_base, 2);
    step();
    NXT = 2'b10;
    step();
    NXT = 2'b00;
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(APP_DONE), 0);
    chk("abort_soc", int'(ADC_SOC), 0);
    chk("abort_pi", int'(ADC_PI), 41);
    chk("abort_err", int'(ERR), 0);
    repeat (60) step();
    chk("abort_socs_after", soc_cnt - soc_base, 2);
    chk("abort_pi_after", int'(ADC_PI), 41);
    chk("abort_done_after", int'(APP_DONE), 0);
    chk("abort_busy_after", int'(BUSY), 0);

    // Reset while in ACC: SOC at edge 9, EOC sampled at edge 14, ACC during 14..15.
    cur_smp  = {10'd300, 10'd300, 10'd300, 10'd300};
    eoc_dly  = 4;
    soc_base = soc_cnt;
    NXT      = 2'b01;
    step();
    NXT = 2'b00;
    repeat (14) step();
    RST = 1'b1;
    step();
    chk("rst_acc_soc", int'(ADC_SOC), 0);
    chk("rst_acc_pi", int'(ADC_PI), 0);
    chk("rst_acc_done", int'(APP_DONE), 0);
    chk("rst_acc_busy", int'(BUSY), 0);
    chk("rst_acc_err", int'(ERR), 0);
    RST  = 1'b0;
    base = soc_cnt;
    step();
    stray_tog = ~stray_tog;
    repeat (30) step();
    chk("stray_busy", int'(BUSY), 0);
    chk("stray_done", int'(APP_DONE), 0);
    chk("stray_pi", int'(ADC_PI), 0);
    chk("stray_err", int'(ERR), 0);
    chk("stray_socs", soc_cnt - base, 0);

    run_meas({10'd10, 10'd10, 10'd10, 10'd10}, 1, 2'b00, -1, lat, socs, b0, e0, d0);
    chk("post_rst_lat", lat, 48);
    chk("post_rst_pi", int'(ADC_PI), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
